// File: rtl/fft_pkg.sv
// Shared constants, FSM state encoding and the bit-reversal helper for the
// 32-point in-place FFT memory sequencer.
package fft_pkg;

   localparam int DW = 16;
   localparam int AW = 5;
   localparam int N  = 1 << AW;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_UNLOAD = 3'd4
   } state_t;

   function automatic logic [4:0] bitrev5(input logic [4:0] i_v);
      return {i_v[0], i_v[1], i_v[2], i_v[3], i_v[4]};
   endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT butterfly addressing: maps (stage, butterfly) to the two
// in-place operand addresses and the twiddle index.
module fft_addr_gen
   import fft_pkg::*;
(
   input  logic [2:0]    i_s,
   input  logic [3:0]    i_k,
   output logic [AW-1:0] o_a,
   output logic [AW-1:0] o_b,
   output logic [3:0]    o_tw
);

   logic [AW-1:0] w_k;
   logic [AW-1:0] w_span;
   logic [AW-1:0] w_mask;
   logic [AW-1:0] w_hi;
   logic [AW-1:0] w_a;

   // Insert a zero bit at position s of k to get the upper-wing index.
   always_comb begin
      w_k    = {1'b0, i_k};
      w_span = 5'd1 << i_s;
      w_mask = w_span - 5'd1;
      w_hi   = (w_k >> i_s) << (i_s + 3'd1);
      w_a    = w_hi | (w_k & w_mask);
      o_a    = w_a;
      o_b    = w_a + w_span;
      o_tw   = (i_k & w_mask[3:0]) << (3'd4 - i_s);
   end

endmodule

// File: rtl/fft_ram_sequencer.sv
// Drives the dual-port FFT RAM through load (bit-reversed), 5x16 in-place
// butterflies via an external unit, and natural-order unload.
module fft_ram_sequencer #(
   parameter int DW = fft_pkg::DW,
   parameter int AW = fft_pkg::AW
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_start,
   output logic          o_busy,
   output logic          o_done,
   input  logic          i_in_valid,
   output logic          o_in_ready,
   input  logic [DW-1:0] i_in_data,
   output logic          o_out_valid,
   input  logic          i_out_ready,
   output logic [DW-1:0] o_out_data,
   output logic          o_out_last,
   output logic          o_ram_ena,
   output logic          o_ram_enb,
   output logic [AW-1:0] o_ram_addra,
   output logic [AW-1:0] o_ram_addrb,
   output logic [DW-1:0] o_ram_dia,
   output logic [DW-1:0] o_ram_dib,
   input  logic [DW-1:0] i_ram_doa,
   input  logic [DW-1:0] i_ram_dob,
   output logic          o_bf_valid,
   input  logic          i_bf_ready,
   output logic [DW-1:0] o_bf_a,
   output logic [DW-1:0] o_bf_b,
   output logic [3:0]    o_bf_tw,
   input  logic          i_bf_res_valid,
   input  logic [DW-1:0] i_bf_res_a,
   input  logic [DW-1:0] i_bf_res_b
);
   import fft_pkg::*;

   localparam logic [AW-1:0] SMP_LAST = AW'(N - 1);
   localparam logic [AW-1:0] SMP_ONE  = AW'(1);
   localparam logic [3:0]    K_LAST   = 4'd15;
   localparam logic [2:0]    S_LAST   = 3'd4;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [AW-1:0] r_smp;
   logic [AW-1:0] w_smp_nxt;
   logic [2:0]    r_s;
   logic [2:0]    w_s_nxt;
   logic [3:0]    r_k;
   logic [3:0]    w_k_nxt;
   logic          r_done;
   logic          w_done_nxt;
   logic [AW-1:0] w_a;
   logic [AW-1:0] w_b;
   logic [3:0]    w_tw;

   fft_addr_gen u_addr_gen (
      .i_s  (r_s),
      .i_k  (r_k),
      .o_a  (w_a),
      .o_b  (w_b),
      .o_tw (w_tw)
   );

   // State, counters and the done pulse; reset aborts any pass.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_smp   <= {AW{1'b0}};
         r_s     <= 3'd0;
         r_k     <= 4'd0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_smp   <= w_smp_nxt;
         r_s     <= w_s_nxt;
         r_k     <= w_k_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign o_done = r_done;

   // Next state, counter updates and RAM/stream/butterfly port drive.
   always_comb begin
      w_state_nxt = r_state;
      w_smp_nxt   = r_smp;
      w_s_nxt     = r_s;
      w_k_nxt     = r_k;
      w_done_nxt  = 1'b0;
      o_busy      = (r_state != ST_IDLE);
      o_in_ready  = 1'b0;
      o_out_valid = 1'b0;
      o_out_data  = {DW{1'b0}};
      o_out_last  = 1'b0;
      o_ram_ena   = 1'b0;
      o_ram_enb   = 1'b0;
      o_ram_addra = {AW{1'b0}};
      o_ram_addrb = {AW{1'b0}};
      o_ram_dia   = {DW{1'b0}};
      o_ram_dib   = {DW{1'b0}};
      o_bf_valid  = 1'b0;
      o_bf_a      = {DW{1'b0}};
      o_bf_b      = {DW{1'b0}};
      o_bf_tw     = 4'd0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_state_nxt = ST_LOAD;
               w_smp_nxt   = {AW{1'b0}};
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_LOAD: begin
            o_in_ready = 1'b1;
            if (i_in_valid) begin
               o_ram_ena   = 1'b1;
               o_ram_addra = bitrev5(r_smp);
               o_ram_dia   = i_in_data;
               w_smp_nxt   = r_smp + SMP_ONE;
               if (r_smp == SMP_LAST) begin
                  w_state_nxt = ST_ISSUE;
                  w_s_nxt     = 3'd0;
                  w_k_nxt     = 4'd0;
               end else begin
                  w_state_nxt = ST_LOAD;
               end
            end else begin
               w_state_nxt = ST_LOAD;
            end
         end
         ST_ISSUE: begin
            o_ram_addra = w_a;
            o_ram_addrb = w_b;
            o_bf_valid  = 1'b1;
            o_bf_a      = i_ram_doa;
            o_bf_b      = i_ram_dob;
            o_bf_tw     = w_tw;
            if (i_bf_ready) begin
               w_state_nxt = ST_WAIT;
            end else begin
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_WAIT: begin
            o_ram_addra = w_a;
            o_ram_addrb = w_b;
            // Results land in place during the strobe cycle itself.
            if (i_bf_res_valid) begin
               o_ram_ena = 1'b1;
               o_ram_enb = 1'b1;
               o_ram_dia = i_bf_res_a;
               o_ram_dib = i_bf_res_b;
               if (r_k == K_LAST) begin
                  w_k_nxt = 4'd0;
                  if (r_s == S_LAST) begin
                     w_state_nxt = ST_UNLOAD;
                     w_s_nxt     = 3'd0;
                     w_smp_nxt   = {AW{1'b0}};
                  end else begin
                     w_state_nxt = ST_ISSUE;
                     w_s_nxt     = r_s + 3'd1;
                  end
               end else begin
                  w_state_nxt = ST_ISSUE;
                  w_k_nxt     = r_k + 4'd1;
               end
            end else begin
               w_state_nxt = ST_WAIT;
            end
         end
         ST_UNLOAD: begin
            o_ram_addra = r_smp;
            o_out_valid = 1'b1;
            o_out_data  = i_ram_doa;
            o_out_last  = (r_smp == SMP_LAST);
            if (i_out_ready) begin
               w_smp_nxt = r_smp + SMP_ONE;
               if (r_smp == SMP_LAST) begin
                  w_state_nxt = ST_IDLE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = ST_UNLOAD;
               end
            end else begin
               w_state_nxt = ST_UNLOAD;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fft_ram_sequencer.sv
// Directed bench: behavioural RAM and butterfly models around fft_ram_sequencer,
// checking results, addressing, pass length, handshake stability and reset abort.
module tb_fft_ram_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        busy;
   logic        done;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_last;
   logic        ram_ena;
   logic        ram_enb;
   logic [4:0]  addra;
   logic [4:0]  addrb;
   logic [15:0] dia;
   logic [15:0] dib;
   logic [15:0] doa;
   logic [15:0] dob;
   logic        bf_valid;
   logic        bf_ready;
   logic [15:0] bf_a;
   logic [15:0] bf_b;
   logic [3:0]  bf_tw;
   logic        bf_res_valid;
   logic [15:0] bf_res_a;
   logic [15:0] bf_res_b;

   fft_ram_sequencer dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_busy(busy), .o_done(done),
      .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
      .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
      .o_out_last(out_last), .o_ram_ena(ram_ena), .o_ram_enb(ram_enb),
      .o_ram_addra(addra), .o_ram_addrb(addrb), .o_ram_dia(dia), .o_ram_dib(dib),
      .i_ram_doa(doa), .i_ram_dob(dob), .o_bf_valid(bf_valid), .i_bf_ready(bf_ready),
      .o_bf_a(bf_a), .o_bf_b(bf_b), .o_bf_tw(bf_tw), .i_bf_res_valid(bf_res_valid),
      .i_bf_res_a(bf_res_a), .i_bf_res_b(bf_res_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // 32x16 dual-port RAM: asynchronous read, synchronous write.
   logic [15:0] mem [0:31];
   always @(posedge clk) begin
      if (ram_ena) mem[addra] <= dia;
      if (ram_enb) mem[addrb] <= dib;
   end
   assign doa = mem[addra];
   assign dob = mem[addrb];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Real-part twiddle cos(pi*tw/16) in Q14 for the scaled butterfly model.
   int cos_q14 [16] = '{16384, 16069, 15137, 13623, 11585, 9102, 6270, 3196,
                        0, -3196, -6270, -9102, -11585, -13623, -15137, -16069};

   logic [15:0] src [32];
   logic [15:0] got [32];
   logic [4:0]  obs_a [80];
   logic [4:0]  obs_b [80];
   logic [3:0]  obs_tw [80];
   bit  in_stall, bf_stall, out_stall, bf_real;
   int  out_cnt, last_cnt, last_idx, done_cnt, done_cyc, acc_cnt, issue_cnt, bf_viol;
   int  t_first, t_last;
   bit  bf_pending;
   logic [15:0] model_a, model_b;

   // Butterfly unit model: one outstanding operation, optional random stalls.
   initial begin
      bit        hold_vld;
      logic [35:0] hold_ops;
      int        t, ra, rb;
      hold_vld = 1'b0;
      hold_ops = 36'd0;
      bf_pending = 1'b0;
      bf_ready = 1'b0;
      bf_res_valid = 1'b0;
      bf_res_a = 16'd0;
      bf_res_b = 16'd0;
      forever begin
         @(posedge clk); #1;
         if (bf_pending) begin
            bf_ready = 1'b0;
            bf_res_valid = bf_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            bf_res_a = model_a;
            bf_res_b = model_b;
         end else begin
            bf_res_valid = 1'b0;
            bf_ready = bf_stall ? ($urandom_range(0, 2) == 0) : 1'b1;
         end
         @(negedge clk);
         if (bf_valid) begin
            if (hold_vld && ({bf_a, bf_b, bf_tw} != hold_ops)) bf_viol++;
            hold_vld = !bf_ready;
            hold_ops = {bf_a, bf_b, bf_tw};
         end else begin
            hold_vld = 1'b0;
         end
         if (!rst_n) begin
            bf_pending = 1'b0;
            hold_vld = 1'b0;
         end else if (bf_pending && bf_res_valid) begin
            bf_pending = 1'b0;
         end else if (!bf_pending && bf_valid && bf_ready) begin
            if (issue_cnt < 80) begin
               obs_a[issue_cnt]  = addra;
               obs_b[issue_cnt]  = addrb;
               obs_tw[issue_cnt] = bf_tw;
            end
            issue_cnt++;
            if (bf_real) begin
               t  = (int'($signed(bf_b)) * cos_q14[bf_tw]) >>> 14;
               ra = (int'($signed(bf_a)) + t) >>> 1;
               rb = (int'($signed(bf_a)) - t) >>> 1;
               model_a = ra[15:0];
               model_b = rb[15:0];
            end else begin
               model_a = bf_a;
               model_b = bf_b;
            end
            bf_pending = 1'b1;
         end
      end
   end

   // Result sink and stream/done monitors.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         out_ready = out_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         @(negedge clk);
         if (in_valid && in_ready) begin
            if (acc_cnt == 0) t_first = cyc;
            acc_cnt++;
         end
         if (out_valid && out_ready) begin
            if (out_cnt < 32) got[out_cnt] = out_data;
            if (out_last) begin
               last_cnt++;
               last_idx = out_cnt;
            end
            out_cnt++;
            t_last = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic clear_stats();
      out_cnt = 0; last_cnt = 0; last_idx = -1; done_cnt = 0; done_cyc = -1;
      acc_cnt = 0; issue_cnt = 0; bf_viol = 0; t_first = -1; t_last = -1;
   endtask

   task automatic load_samples(input bit pulse);
      int idx = 0;
      int guard = 0;
      @(posedge clk); #1;
      start = 1'b1;
      in_valid = 1'b0;
      while (idx < 32 && guard < 5000) begin
         @(posedge clk); #1;
         start = pulse && (idx == 10);
         in_valid = in_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         in_data = src[idx];
         @(negedge clk);
         if (in_valid && in_ready) idx++;
         guard++;
      end
      check_eq("load_cnt", 64'(idx), 64'd32);
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1;
      in_data = 16'hdead;
   endtask

   task automatic wait_done(input bit pulse);
      int guard = 0;
      while (done_cnt == 0 && guard < 20000) begin
         @(posedge clk); #1;
         start = pulse && (out_cnt >= 5) && (out_cnt < 10);
         @(negedge clk);
         guard++;
      end
      start = 1'b0;
      check_eq("done_seen", 64'(done_cnt != 0), 64'd1);
      repeat (3) @(negedge clk);
      check_eq("idle_busy", 64'(busy), 64'd0);
   endtask

   task automatic check_pass(input string tag, input bit impulse);
      logic [4:0]  jj;
      logic [15:0] exp_v;
      for (int j = 0; j < 32; j++) begin
         jj = j[4:0];
         exp_v = impulse ? 16'h0008 : {11'd0, jj[0], jj[1], jj[2], jj[3], jj[4]};
         check_eq($sformatf("%s_out%0d", tag, j), 64'(got[j]), 64'(exp_v));
      end
      check_eq({tag, "_out_cnt"}, 64'(out_cnt), 64'd32);
      check_eq({tag, "_acc_cnt"}, 64'(acc_cnt), 64'd32);
      check_eq({tag, "_issues"}, 64'(issue_cnt), 64'd80);
      check_eq({tag, "_last_cnt"}, 64'(last_cnt), 64'd1);
      check_eq({tag, "_last_idx"}, 64'(last_idx), 64'd31);
      check_eq({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
      check_eq({tag, "_done_cyc"}, 64'(done_cyc), 64'(t_last + 1));
      check_eq({tag, "_bf_stable"}, 64'(bf_viol), 64'd0);
   endtask

   task automatic run_pass(input string tag, input bit stall, input bit pulse,
                           input bit real_bf);
      clear_stats();
      in_stall = stall; bf_stall = stall; out_stall = stall; bf_real = real_bf;
      load_samples(pulse);
      wait_done(pulse);
      check_pass(tag, real_bf);
   endtask

   initial begin
      int guard;
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 16'd0;
      in_stall = 1'b0; bf_stall = 1'b0; out_stall = 1'b0; bf_real = 1'b0;
      clear_stats();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_ctrl", 64'({busy, done, in_ready, out_valid, out_last, bf_valid,
                                ram_ena, ram_enb}), 64'd0);
      check_eq("rst_addr", 64'({addra, addrb, bf_tw}), 64'd0);
      check_eq("rst_wdata", 64'({dia, dib}), 64'd0);
      check_eq("rst_rdata", 64'({bf_a, bf_b, out_data}), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 32; i++) src[i] = 16'(i);
      run_pass("thru", 1'b0, 1'b0, 1'b0);
      check_eq("pass_len", 64'(t_last - t_first + 1), 64'd224);
      check_eq("adr_s0k0_a", 64'(obs_a[0]), 64'd0);
      check_eq("adr_s0k0_b", 64'(obs_b[0]), 64'd1);
      check_eq("adr_s0k0_tw", 64'(obs_tw[0]), 64'd0);
      check_eq("adr_s2k5_a", 64'(obs_a[37]), 64'd9);
      check_eq("adr_s2k5_b", 64'(obs_b[37]), 64'd13);
      check_eq("adr_s2k5_tw", 64'(obs_tw[37]), 64'd4);
      check_eq("adr_s4k3_a", 64'(obs_a[67]), 64'd3);
      check_eq("adr_s4k3_b", 64'(obs_b[67]), 64'd19);
      check_eq("adr_s4k3_tw", 64'(obs_tw[67]), 64'd3);

      run_pass("stall", 1'b1, 1'b1, 1'b0);

      for (int i = 0; i < 32; i++) src[i] = 16'd0;
      src[0] = 16'h0100;
      run_pass("impulse", 1'b0, 1'b0, 1'b1);

      // Abort during stage 2, then a clean pass must still work.
      for (int i = 0; i < 32; i++) src[i] = 16'(i);
      clear_stats();
      in_stall = 1'b0; bf_stall = 1'b0; out_stall = 1'b0; bf_real = 1'b0;
      load_samples(1'b0);
      guard = 0;
      while (issue_cnt < 37 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      check_eq("abort_reach", 64'(issue_cnt >= 37), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("abort_busy", 64'(busy), 64'd0);
      check_eq("abort_we", 64'({ram_ena, ram_enb}), 64'd0);
      check_eq("abort_hs", 64'({bf_valid, in_ready, out_valid}), 64'd0);
      repeat (2) @(negedge clk);
      run_pass("after_abort", 1'b1, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
